// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC sequencer: FSM state encoding,
// a constant-evaluable ceil(log2) and the minimum accumulator width rule.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_OUT,
        ST_DONE
    } conv_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Narrowest accumulator that cannot overflow on a full kernel of
    // worst-case signed products.
    function automatic int acc_width_min(input int bitwidth, input int taps);
        return 2 * bitwidth + clog2(taps);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: both operands sign-extended to the accumulator
// width, sum wraps modulo 2^ACC_WIDTH.
module conv_mac
    import conv_pkg::*;
#(
    parameter int BITWIDTH  = 3,
    parameter int ACC_WIDTH = 8
) (
    input  logic                        clk_en,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [BITWIDTH-1:0]  a,
    input  logic signed [BITWIDTH-1:0]  b,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [ACC_WIDTH-1:0] a_ext;
    logic signed [ACC_WIDTH-1:0] b_ext;
    logic signed [ACC_WIDTH-1:0] prod;

    assign a_ext = ACC_WIDTH'(a);
    assign b_ext = ACC_WIDTH'(b);
    assign prod  = a_ext * b_ext;

    // Accumulator register: clear has priority over accumulate.
    always_ff @(posedge clk_en) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/conv_mac_seq.sv
// Sequencer for the convolution window buffer: sweeps the output map in
// row-major order, walks the kernel one element per cycle, accumulates the
// products and emits each pixel on a valid/ready stream.
module conv_mac_seq
    import conv_pkg::*;
#(
    parameter int WEIGHT_WIDTH  = 2,
    parameter int WEIGHT_HEIGHT = 2,
    parameter int RESULT_WIDTH  = 3,
    parameter int RESULT_HEIGHT = 3,
    parameter int STRIDE        = 1,
    parameter int BITWIDTH      = 3,
    parameter int ACC_WIDTH     = 8
) (
    input  logic                        clk_en,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        conv_on,
    output logic [31:0]                 anchor_l,
    output logic [31:0]                 anchor_c,
    output logic [3:0]                  buf_l,
    output logic [3:0]                  buf_c,
    input  logic signed [BITWIDTH-1:0]  img_cal,
    input  logic signed [BITWIDTH-1:0]  wei_cal,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic                        out_last
);

    localparam int          TAPS     = WEIGHT_WIDTH * WEIGHT_HEIGHT;
    localparam logic [3:0]  KC_LAST  = 4'(WEIGHT_WIDTH - 1);
    localparam logic [3:0]  KL_LAST  = 4'(WEIGHT_HEIGHT - 1);
    localparam logic [31:0] COL_LAST = 32'(RESULT_WIDTH - 1);
    localparam logic [31:0] ROW_LAST = 32'(RESULT_HEIGHT - 1);
    localparam logic [31:0] STRIDE_W = 32'(STRIDE);

    if (ACC_WIDTH < acc_width_min(BITWIDTH, TAPS)) begin : g_acc_width_check
        $error("ACC_WIDTH too narrow for BITWIDTH and kernel size");
    end

    conv_state_t state;
    logic [31:0] out_row;
    logic [31:0] out_col;
    logic [31:0] next_row;
    logic [31:0] next_col;
    logic        kernel_last;
    logic        pixel_last;
    logic        mac_clr;
    logic        mac_en;

    assign kernel_last = (buf_l == KL_LAST) && (buf_c == KC_LAST);
    assign pixel_last  = (out_row == ROW_LAST) && (out_col == COL_LAST);

    // The accumulator reads zero whenever no pixel is being built or shown,
    // and only moves during MAC, so back-pressure freezes out_data.
    assign mac_clr = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DONE)
                   || ((state == ST_OUT) && out_ready);
    assign mac_en  = (state == ST_MAC);

    // Row-major successor of the current output pixel.
    always_comb begin
        next_col = out_col + 32'd1;
        next_row = out_row;
        if (out_col == COL_LAST) begin
            next_col = '0;
            next_row = out_row + 32'd1;
        end
    end

    // Sweep FSM with registered control outputs and index counters.
    always_ff @(posedge clk_en) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            conv_on   <= 1'b0;
            anchor_l  <= '0;
            anchor_c  <= '0;
            buf_l     <= '0;
            buf_c     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        conv_on  <= 1'b1;
                        out_row  <= '0;
                        out_col  <= '0;
                        anchor_l <= '0;
                        anchor_c <= '0;
                        buf_l    <= '0;
                        buf_c    <= '0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    if (kernel_last) begin
                        state     <= ST_OUT;
                        out_valid <= 1'b1;
                        out_last  <= pixel_last;
                    end else if (buf_c == KC_LAST) begin
                        buf_c <= '0;
                        buf_l <= buf_l + 4'd1;
                    end else begin
                        buf_c <= buf_c + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        buf_l     <= '0;
                        buf_c     <= '0;
                        if (out_last) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            conv_on  <= 1'b0;
                            anchor_l <= '0;
                            anchor_c <= '0;
                        end else begin
                            state    <= ST_LOAD;
                            out_row  <= next_row;
                            out_col  <= next_col;
                            anchor_l <= next_row * STRIDE_W;
                            anchor_c <= next_col * STRIDE_W;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    conv_mac #(
        .BITWIDTH  (BITWIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk_en (clk_en),
        .rst    (rst),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      (img_cal),
        .b      (wei_cal),
        .acc    (out_data)
    );

endmodule

// File: tb/tb_conv_mac_seq.sv
// Bench for conv_mac_seq: two instances (3x3 map stride 1, 2x2 map stride 2)
// fed by a window model over a shared 4x4 image and 2x2 kernel, checked
// against a direct convolution computed from the image arrays.
module tb_conv_mac_seq;

    logic clk;
    logic rst;
    logic start;
    logic out_ready;
    logic sel;
    int   cyc_cnt;
    int   n_checks;
    int   n_pass;

    logic signed [2:0] img [4][4];
    logic signed [2:0] wei [2][2];

    logic              busy0, done0, conv_on0, valid0, last0;
    logic [31:0]       al0, ac0;
    logic [3:0]        bl0, bc0;
    logic signed [2:0] img0, wei0;
    logic signed [7:0] data0;

    logic              busy1, done1, conv_on1, valid1, last1;
    logic [31:0]       al1, ac1;
    logic [3:0]        bl1, bc1;
    logic signed [2:0] img1, wei1;
    logic signed [7:0] data1;

    logic              m_busy, m_done, m_conv_on, m_valid, m_last;
    logic [31:0]       m_al, m_ac;
    logic [3:0]        m_bl, m_bc;
    logic [7:0]        m_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    conv_mac_seq u_dut0 (
        .clk_en(clk), .rst(rst), .start(start & ~sel), .busy(busy0), .done(done0),
        .conv_on(conv_on0), .anchor_l(al0), .anchor_c(ac0), .buf_l(bl0), .buf_c(bc0),
        .img_cal(img0), .wei_cal(wei0), .out_valid(valid0), .out_ready(out_ready),
        .out_data(data0), .out_last(last0)
    );

    conv_mac_seq #(.RESULT_WIDTH(2), .RESULT_HEIGHT(2), .STRIDE(2)) u_dut1 (
        .clk_en(clk), .rst(rst), .start(start & sel), .busy(busy1), .done(done1),
        .conv_on(conv_on1), .anchor_l(al1), .anchor_c(ac1), .buf_l(bl1), .buf_c(bc1),
        .img_cal(img1), .wei_cal(wei1), .out_valid(valid1), .out_ready(out_ready),
        .out_data(data1), .out_last(last1)
    );

    function automatic logic signed [2:0] win_img(input logic [31:0] al, input logic [3:0] bl,
                                                  input logic [31:0] ac, input logic [3:0] bc);
        logic [31:0] r, c;
        r = al + {28'd0, bl};
        c = ac + {28'd0, bc};
        if (r < 32'd4 && c < 32'd4) return img[r[1:0]][c[1:0]];
        return 3'sd0;
    endfunction

    function automatic logic signed [2:0] win_wei(input logic [3:0] bl, input logic [3:0] bc);
        if (bl < 4'd2 && bc < 4'd2) return wei[bl[0]][bc[0]];
        return 3'sd0;
    endfunction

    always_comb begin
        img0 = win_img(al0, bl0, ac0, bc0);
        wei0 = win_wei(bl0, bc0);
        img1 = win_img(al1, bl1, ac1, bc1);
        wei1 = win_wei(bl1, bc1);
    end

    assign m_busy    = sel ? busy1    : busy0;
    assign m_done    = sel ? done1    : done0;
    assign m_conv_on = sel ? conv_on1 : conv_on0;
    assign m_valid   = sel ? valid1   : valid0;
    assign m_last    = sel ? last1    : last0;
    assign m_al      = sel ? al1      : al0;
    assign m_ac      = sel ? ac1      : ac0;
    assign m_bl      = sel ? bl1      : bl0;
    assign m_bc      = sel ? bc1      : bc0;
    assign m_data    = sel ? data1    : data0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic fill_const(input logic signed [2:0] iv, input logic signed [2:0] wv);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) img[i][j] = iv;
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) wei[i][j] = wv;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) img[i][j] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) wei[i][j] = 3'($urandom_range(0, 7));
    endtask

    // One full sweep on instance s. stall_pix/stall_len force back-pressure on
    // one pixel, rnd adds random stalls, poke pulses start while busy.
    task automatic run_sweep(input bit s, input int stall_pix, input int stall_len,
                             input bit rnd, input bit poke);
        int          rsz, st, n, pix, cyc, stalls, held, vcnt, t0, sum;
        bit          stall;
        logic [7:0]  exp_d [$];
        logic [31:0] exp_l [$];
        logic [31:0] exp_c [$];
        logic [7:0]  hold_d;
        logic [31:0] hold_l, hold_c;
        logic [3:0]  hold_bl, hold_bc;

        rsz = s ? 2 : 3;
        st  = s ? 2 : 1;
        for (int r = 0; r < rsz; r++) begin
            for (int c = 0; c < rsz; c++) begin
                sum = 0;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        sum += int'(img[r*st+i][c*st+j]) * int'(wei[i][j]);
                exp_d.push_back(8'(sum));
                exp_l.push_back(32'(r * st));
                exp_c.push_back(32'(c * st));
            end
        end
        n = rsz * rsz;

        sel = s;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc_cnt;
        pix = 0; cyc = 0; stalls = 0; held = 0; vcnt = 0;
        hold_d = '0; hold_l = '0; hold_c = '0; hold_bl = '0; hold_bc = '0;

        while (pix < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 3);
            check_eq("early_done", {31'd0, m_done}, 32'd0);
            if (m_valid) begin
                if (vcnt == 0) begin
                    hold_d = m_data; hold_l = m_al; hold_c = m_ac; hold_bl = m_bl; hold_bc = m_bc;
                end else begin
                    check_eq($sformatf("hold_data_p%0d", pix), {24'd0, m_data}, {24'd0, hold_d});
                    check_eq($sformatf("hold_al_p%0d", pix), m_al, hold_l);
                    check_eq($sformatf("hold_ac_p%0d", pix), m_ac, hold_c);
                    check_eq($sformatf("hold_buf_p%0d", pix), {24'd0, m_bl, m_bc}, {24'd0, hold_bl, hold_bc});
                end
                stall = (pix == stall_pix && held < stall_len) || (rnd && $urandom_range(0, 2) == 0);
                if (stall) begin
                    out_ready = 1'b0;
                    stalls++;
                    vcnt++;
                    if (pix == stall_pix) held++;
                end else begin
                    out_ready = 1'b1;
                    check_eq($sformatf("data_p%0d", pix), {24'd0, m_data}, {24'd0, exp_d[pix]});
                    check_eq($sformatf("anchor_l_p%0d", pix), m_al, exp_l[pix]);
                    check_eq($sformatf("anchor_c_p%0d", pix), m_ac, exp_c[pix]);
                    check_eq($sformatf("last_p%0d", pix), {31'd0, m_last}, {31'd0, pix == n - 1});
                    check_eq($sformatf("on_p%0d", pix), {30'd0, m_busy, m_conv_on}, 32'd3);
                    pix++;
                    vcnt = 0;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        start = 1'b0;
        check_eq("sweep_pixels", 32'(pix), 32'(n));

        @(negedge clk);
        check_eq("done_pulse", {31'd0, m_done}, 32'd1);
        check_eq("done_conv_on", {31'd0, m_conv_on}, 32'd0);
        check_eq("done_valid", {31'd0, m_valid}, 32'd0);
        check_eq("done_latency", 32'(cyc_cnt), 32'(t0 + n * 6 + stalls));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_width", {31'd0, m_done}, 32'd0);
        check_eq("idle_busy", {31'd0, m_busy}, 32'd0);
        check_eq("idle_conv_on", {31'd0, m_conv_on}, 32'd0);
    endtask

    task automatic run_abort();
        int t0;
        sel = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc_cnt;
        for (int k = 0; k < 27; k++) @(negedge clk);
        check_eq("abort_cycle", 32'(cyc_cnt), 32'(t0 + 27));
        check_eq("abort_buf", {24'd0, m_bl, m_bc}, {24'd0, 4'd1, 4'd0});
        check_eq("abort_anchor", {m_al[15:0], m_ac[15:0]}, {16'd1, 16'd1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_conv_on", {31'd0, m_conv_on}, 32'd0);
        check_eq("abort_busy", {31'd0, m_busy}, 32'd0);
        check_eq("abort_valid", {31'd0, m_valid}, 32'd0);
        check_eq("abort_anchor0", m_al | m_ac, 32'd0);
        for (int k = 0; k < 8; k++) begin
            check_eq("abort_no_done", {30'd0, m_done, m_busy}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc_cnt = 0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
        fill_const(3'sd1, 3'sd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'd0, m_busy}, 32'd0);
        check_eq("rst_done", {31'd0, m_done}, 32'd0);
        check_eq("rst_conv_on", {31'd0, m_conv_on}, 32'd0);
        check_eq("rst_anchors", m_al | m_ac, 32'd0);
        check_eq("rst_buf", {24'd0, m_bl, m_bc}, 32'd0);
        check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_last", {31'd0, m_last}, 32'd0);
        check_eq("rst_data", {24'd0, m_data}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_hold", {m_busy, m_done, m_conv_on, m_valid, m_data, m_bl, m_bc, 12'd0},
                 32'd0);
        check_eq("idle_hold_anchor", m_al | m_ac, 32'd0);

        fill_const(3'sd1, 3'sd1);
        run_sweep(1'b0, -1, 0, 1'b0, 1'b0);

        fill_const(-3'sd1, 3'sd3);
        run_sweep(1'b0, -1, 0, 1'b0, 1'b0);

        fill_rand();
        run_sweep(1'b0, 0, 5, 1'b0, 1'b1);

        fill_rand();
        run_sweep(1'b1, -1, 0, 1'b1, 1'b0);

        fill_rand();
        run_abort();
        run_sweep(1'b0, -1, 0, 1'b1, 1'b0);

        for (int it = 0; it < 3; it++) begin
            fill_rand();
            run_sweep(1'(it % 2), $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, 1'(it == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_mac_seq.md
Name: conv_mac_seq

Overview:
- Sequencer and multiply-accumulate stage that sits directly downstream of the convolution window buffer. It drives that buffer's conv_on, anchor_l/anchor_c and buf_l/buf_c inputs.
- It consumes the img_cal/wei_cal element pair, one kernel element per cycle. It accumulates signed products into one output pixel and presents each pixel on a valid/ready stream in row-major output order.
- One start pulse sweeps the full result map.

Parameters:
- WEIGHT_WIDTH, 2, kernel columns
- WEIGHT_HEIGHT, 2, kernel rows
- RESULT_WIDTH, 3, output map columns
- RESULT_HEIGHT, 3, output map rows
- STRIDE, 1, anchor step in padded image coordinates
- BITWIDTH, 3, element width, signed two's complement
- ACC_WIDTH, 8, accumulator/output width; must be at least 2*BITWIDTH+clog2(WEIGHT_WIDTH*WEIGHT_HEIGHT)

Ports:
- clk_en  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- busy  out  1  high in LOAD, MAC and OUT
- done  out  1  one-cycle pulse after the final pixel handshake
- conv_on  out  1  window buffer enable
- anchor_l  out  32  window top row = out_row*STRIDE
- anchor_c  out  32  window left column = out_col*STRIDE
- buf_l  out  4  kernel row select
- buf_c  out  4  kernel column select
- img_cal  in  BITWIDTH  selected window element (registered upstream)
- wei_cal  in  BITWIDTH  selected weight element (combinational upstream)
- out_valid  out  1  pixel available
- out_ready  in  1  downstream accepts
- out_data  out  ACC_WIDTH  signed pixel sum
- out_last  out  1  qualifies the final pixel of the map

Behaviour:
- Synchronous, active-high reset clock/reset. Single clock clk_en; rst synchronous, active-high.
- Reset values: all outputs 0, state IDLE. Reset in any state, including mid-MAC or OUT, aborts the sweep: no done pulse, out_valid drops on the next edge.
- IDLE:
  - conv_on=0; anchors, buf indices and out_valid at 0.
  - start=1 moves to LOAD with out_row=out_col=0 and acc cleared.
- LOAD (1 cycle):
  - conv_on=1; anchors set from out_row/out_col; buf_l=buf_c=0; acc cleared.
  - The upstream window register captures at the end of this cycle.
  - Next state is MAC.
- MAC (WEIGHT_WIDTH*WEIGHT_HEIGHT cycles):
  - conv_on=1; anchors held.
  - buf_c is the inner index and buf_l the outer, in row-major order.
  - Each cycle: acc <= acc + sext(img_cal)*sext(wei_cal). Operands are sign-extended to ACC_WIDTH; the sum wraps modulo 2^ACC_WIDTH with no saturation.
  - On the last kernel element the final sum is registered into out_data and the state moves to OUT.
- OUT:
  - conv_on=1; out_valid=1; out_last=1 iff out_row=RESULT_HEIGHT-1 and out_col=RESULT_WIDTH-1.
  - out_data, anchors and buf indices are held stable until out_ready=1.
  - On handshake at the last pixel, move to DONE. Otherwise advance out_col, wrapping to 0 with out_row incremented, and move to LOAD.
- DONE (1 cycle): done=1, conv_on=0, then IDLE.
- start is ignored outside IDLE, including in the DONE cycle.
- Minimum per-pixel cost is 1+K+1 cycles, where K=WEIGHT_WIDTH*WEIGHT_HEIGHT. Back-pressure only extends OUT.
- out_valid never deasserts without a handshake except on reset.

Decomposition:
- Shared package/include conv_pkg:
  - state encodings IDLE/LOAD/MAC/OUT/DONE;
  - a clog2 constant function;
  - the ACC_WIDTH derivation.
- One sub-module conv_mac: signed multiply-accumulate with clr, en, inputs a and b, and output acc of ACC_WIDTH. The top module holds the FSM and the index counters.

Test Plan:
- Reset: assert rst for 3 cycles -> all outputs 0, state IDLE; deassert with start low -> outputs remain 0.
- Defaults, window model all img=1 and wei=1, out_ready held high, start pulse at cycle 0:
  - nine pixels, each with out_data=4;
  - anchors sequence (0,0)…(2,2) row-major;
  - out_last only on the 9th pixel;
  - done exactly one cycle after the 9th handshake, 55 cycles after start.
- Signed arithmetic: img=3'b111 (-1), wei=3'b011 (3) -> every out_data=8'hF4 (-12).
- Back-pressure: hold out_ready=0 for 5 cycles on pixel 0 -> out_valid stays 1; out_data, anchors and buf indices are unchanged; no MAC activity; the sweep resumes correctly after release.
- STRIDE=2 with RESULT 2x2 -> anchor pairs (0,0),(0,2),(2,0),(2,2).
- Abort and ignored start:
  - rst asserted during the 3rd MAC cycle of pixel 4 -> next cycle IDLE, conv_on=0, no done pulse; a new start restarts at anchor (0,0).
  - start pulsed while busy -> no effect.
